// File: rtl/div_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : div_seq_pkg                                        |
// | Description : Shared types and constants for the sequential      |
// |               restoring divider (FSM encoding, ready levels,     |
// |               default operand width).                            |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package div_seq_pkg;

  // Default operand width; quotient and remainder share it.
  localparam int c_DEF_DATA_W = 32;

  // Ready levels presented on ready_o.
  localparam logic c_READY     = 1'b1;
  localparam logic c_NOT_READY = 1'b0;

  // Divider control states.
  typedef enum logic [1:0] {
    FREE    = 2'd0,  // idle, waiting for a request
    BY_ZERO = 2'd1,  // divisor was zero, result is forced to 0
    ON      = 2'd2,  // iterating shift-subtract steps
    END     = 2'd3   // result presented until the requester drops start_i
  } div_state_t;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : div_seq_step                                       |
// | Description : One combinational restoring-division step. Shifts  |
// |               the next dividend bit into the partial remainder,  |
// |               trial-subtracts the divisor and shifts the         |
// |               resulting quotient bit in at the bottom.           |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module div_seq_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quot,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quot
);

  logic [DATA_W:0] w_partial;
  logic [DATA_W:0] w_diff;
  logic            w_fits;

  // The running remainder is always below the divisor, so the partial
  // remainder is below twice the divisor: a set top bit of the
  // (DATA_W+1)-bit difference means a borrow, i.e. the divisor did not fit.
  assign w_partial = {i_rem, i_quot[DATA_W-1]};
  assign w_diff    = w_partial - {1'b0, i_divisor};
  assign w_fits    = ~w_diff[DATA_W];

  // Keep the difference when the divisor fits, otherwise restore.
  assign o_rem  = w_fits ? w_diff[DATA_W-1:0] : w_partial[DATA_W-1:0];
  assign o_quot = {i_quot[DATA_W-2:0], w_fits};

endmodule : div_seq_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : div_seq                                            |
// | Description : Multi-cycle signed/unsigned restoring divider for  |
// |               the execute stage. One quotient bit per cycle,     |
// |               stalls the pipeline while busy, result held until  |
// |               the request is withdrawn. Cancellable by annul_i.  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = c_DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  // Counter must reach DATA_W itself, hence the +1.
  localparam int                c_CNT_W   = $clog2(DATA_W + 1);
  localparam logic [c_CNT_W-1:0] c_STEPS  = c_CNT_W'(DATA_W);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  div_state_t          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_rem;       // partial remainder
  logic [DATA_W-1:0]   r_quot;      // dividend bits shifting out, quotient bits in
  logic [DATA_W-1:0]   r_divisor;
  logic                r_quot_neg;  // quotient must be negated at the end
  logic                r_rem_neg;   // remainder must be negated at the end
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic [DATA_W-1:0]   w_abs_dividend;
  logic [DATA_W-1:0]   w_abs_divisor;
  logic                w_dividend_neg;
  logic                w_divisor_neg;
  logic [DATA_W-1:0]   w_step_rem;
  logic [DATA_W-1:0]   w_step_quot;
  logic [DATA_W-1:0]   w_quot_fixed;
  logic [DATA_W-1:0]   w_rem_fixed;

  // Operand magnitudes: sign handling only applies in signed mode.
  assign w_dividend_neg = signed_i & opdata1_i[DATA_W-1];
  assign w_divisor_neg  = signed_i & opdata2_i[DATA_W-1];
  assign w_abs_dividend = w_dividend_neg ? -opdata1_i : opdata1_i;
  assign w_abs_divisor  = w_divisor_neg  ? -opdata2_i : opdata2_i;

  // Final sign fix-up. The most-negative dividend over -1 wraps back to
  // itself through the negation, which is the intended no-trap result.
  assign w_quot_fixed = r_quot_neg ? -r_quot : r_quot;
  assign w_rem_fixed  = r_rem_neg  ? -r_rem  : r_rem;

  div_seq_step #(
    .DATA_W    (DATA_W)
  ) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  // Divider control, step counter, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FREE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_result   <= '0;
      r_ready    <= c_NOT_READY;
    end else begin
      case (r_state)
        FREE: begin
          r_result <= '0;
          r_ready  <= c_NOT_READY;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= BY_ZERO;
            end else begin
              r_rem      <= '0;
              r_quot     <= w_abs_dividend;
              r_divisor  <= w_abs_divisor;
              r_quot_neg <= w_dividend_neg ^ w_divisor_neg;
              r_rem_neg  <= w_dividend_neg;
              r_cnt      <= '0;
              r_state    <= ON;
            end
          end
        end

        BY_ZERO: begin
          if (annul_i) begin
            r_state <= FREE;
          end else begin
            r_result <= '0;
            r_ready  <= c_READY;
            r_state  <= END;
          end
        end

        ON: begin
          if (annul_i) begin
            r_cnt   <= '0;
            r_state <= FREE;
          end else if (r_cnt == c_STEPS) begin
            // All quotient bits produced: publish the sign-corrected result.
            r_result <= {w_rem_fixed, w_quot_fixed};
            r_ready  <= c_READY;
            r_state  <= END;
          end else begin
            r_rem  <= w_step_rem;
            r_quot <= w_step_quot;
            r_cnt  <= r_cnt + c_CNT_ONE;
          end
        end

        END: begin
          // Hold the result until the execute stage withdraws its request.
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= c_NOT_READY;
            r_cnt    <= '0;
            r_state  <= FREE;
          end
        end

        default: begin
          r_state <= FREE;
        end
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready;
  // Stall while a request is outstanding and not being flushed.
  assign stall_req_o = start_i & ~r_ready & ~annul_i;

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_div_seq                                         |
// | Description : Directed self-checking bench for div_seq with an   |
// |               expected-result queue and an independent monitor.  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_div_seq;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              annul_i;
  logic              signed_i;
  logic [DATA_W-1:0] opdata1_i;
  logic [DATA_W-1:0] opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic              ready_o;
  logic              stall_req_o;

  int total = 0;
  int bad   = 0;

  logic [2*DATA_W-1:0] exp_q[$];
  logic                ready_d = 1'b0;

  div_seq #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready_o && !ready_d) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready_o=1 result=%h, required no result", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
    ready_d = ready_o;
  end

  // Issue one request, measure latency and stall cycles, optionally hold
  // start_i in END for extra cycles, then withdraw and check the return to idle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int exp_lat, input int hold);
    int  cyc;
    int  stl;
    logic done;
    @(posedge clk); #1;
    exp_q.push_back({er, eq});
    signed_i = sgn; opdata1_i = a; opdata2_i = b; annul_i = 1'b0; start_i = 1'b1;
    cyc = 0; stl = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (stall_req_o) stl++;
      if (ready_o) done = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
        if (cyc == 1) begin
          #1;
          opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~sgn;
        end
      end
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("stall_cycles", 64'(stl), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_result", result_o, {er, eq});
      check("hold_ready", {63'd0, ready_o}, 64'd1);
    end
    start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_ready", {63'd0, ready_o}, 64'd0);
    check("idle_result", result_o, 64'd0);
  endtask

  // Start a request and wait until the given number of steps have been done.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input int steps);
    @(posedge clk); #1;
    signed_i = 1'b0; opdata1_i = a; opdata2_i = b; annul_i = 1'b0; start_i = 1'b1;
    @(posedge clk);               // accepted: latch
    repeat (steps) @(posedge clk); // steps completed
    #1;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_stall_idle", {63'd0, stall_req_o}, 64'd0);
    start_i = 1'b1;
    #1;
    check("rst_stall_req", {63'd0, stall_req_o}, 64'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic unsigned and signed quotient/remainder sign combinations.
    run_div(1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 34, 0);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 34, 0);
    run_div(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 34, 0);
    run_div(1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'h00000002, 32'hFFFFFFFE, 34, 0);
    run_div(1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC, 32'h00000001, 34, 0);
    run_div(1'b0, 32'd5,          32'd10,         32'h00000000, 32'h00000005, 34, 0);
    run_div(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 32'h00000000, 34, 0);

    // Divide by zero.
    run_div(1'b0, 32'd0,          32'd0,          32'h00000000, 32'h00000000, 2, 0);
    run_div(1'b1, 32'd123,        32'd0,          32'h00000000, 32'h00000000, 2, 0);

    // Flush after ten steps: no result, then a fresh request completes.
    start_and_wait(32'd100, 32'd7, 10);
    annul_i = 1'b1;
    #1;
    check("annul_stall", {63'd0, stall_req_o}, 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("annul_no_ready", {63'd0, ready_o}, 64'd0);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h00000000, 34, 0);

    // Request while annulled in FREE is ignored.
    @(posedge clk); #1;
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("free_annul_stall", {63'd0, stall_req_o}, 64'd0);
    run_div(1'b0, 32'd1000, 32'd3, 32'h0000014D, 32'h00000001, 34, 0);

    // Signed overflow wraps; result held while start_i stays high.
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 34, 5);

    // Reset after twenty steps abandons the divide.
    start_and_wait(32'd1000, 32'd3, 20);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_stall", {63'd0, stall_req_o}, 64'd1);
    rst = 1'b0; start_i = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("midrst_no_ready", {63'd0, ready_o}, 64'd0);

    // Recovery after reset.
    run_div(1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 34, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_seq
`default_nettype wire

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand width (quotient and remainder widths equal DATA_W).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start_i  in  1  divide request from execute stage, held high until ready_o seen.
REQ-005 SHALL have port: annul_i  in  1  cancel in-flight divide (pipeline flush).
REQ-006 SHALL have port: signed_i  in  1  1 = signed divide, 0 = unsigned.
REQ-007 SHALL have port: opdata1_i  in  DATA_W  dividend.
REQ-008 SHALL have port: opdata2_i  in  DATA_W  divisor.
REQ-009 SHALL have port: result_o  out  2*DATA_W  {remainder, quotient}.
REQ-010 SHALL have port: ready_o  out  1  result valid.
REQ-011 SHALL have port: stall_req_o  out  1  pipeline stall request to pipeline control.

Function
REQ-012 SHALL implement FSM states FREE, BY_ZERO, ON, END.
REQ-013 In FREE with start_i=1, annul_i=0: divisor zero -> BY_ZERO; else latch operands, clear counter -> ON.
REQ-014 Signed mode: latch absolute values (two's complement negate when MSB=1); record quotient sign = XOR of operand MSBs, remainder sign = dividend MSB.
REQ-015 ON: one restoring shift-subtract step per cycle; 6-bit counter 0..32; after 32nd step -> END.
REQ-016 Latency from start_i accepted in FREE to ready_o=1: 34 cycles (1 latch + 32 steps + 1 END).
REQ-017 On entering END: apply recorded signs by negation; result_o = {rem, quot}; ready_o=1.
REQ-018 BY_ZERO: next cycle -> END with result_o = 0.
REQ-019 END: hold result_o and ready_o=1 while start_i=1; start_i=0 -> FREE, ready_o=0, result_o=0 next cycle.
REQ-020 annul_i=1 in ON or BY_ZERO -> FREE next cycle, ready_o stays 0, no result produced.
REQ-021 annul_i=1 with start_i=1 in FREE: request ignored, remain FREE.
REQ-022 stall_req_o = start_i & ~ready_o & ~annul_i (combinational).
REQ-023 Overflow case signed 0x80000000 / 0xFFFFFFFF: quot = 0x80000000, rem = 0 (wrap, no trap).
REQ-024 Unsigned mode ignores MSB sign handling entirely.
REQ-025 Operands change during ON/END SHALL not affect the result (latched copies used).

Reset
REQ-026 On rst=1 at clk edge: state FREE, counter 0, result_o 0, ready_o 0; stall_req_o follows REQ-022 with ready_o=0.
REQ-027 rst mid-operation SHALL abandon the divide with no output pulse.

Structure
REQ-028 State encodings, ready/not-ready constants and width macros SHALL live in shared defines.vh.
REQ-029 One sub-module div_step (combinational single restoring step: compare, subtract, shift) is natural; FSM, counter, sign fix-up stay in div_seq.

Verification
REQ-030 Unsigned 100 / 7 -> after 34 cycles ready_o=1, result_o = {0x00000002, 0x0000000E}; stall_req_o high exactly 34 cycles.
REQ-031 Signed -7 / 2 -> quot 0xFFFFFFFD (-3), rem 0xFFFFFFFF (-1); signed 7 / -2 -> quot -3, rem 1.
REQ-032 Divisor 0 -> ready_o=1 two cycles after start, result_o = 0.
REQ-033 annul_i pulsed at step 10 of ON -> FREE next cycle, ready_o never asserts; new request 0xFFFFFFFF / 1 then completes with quot 0xFFFFFFFF, rem 0.
REQ-034 Signed 0x80000000 / -1 -> quot 0x80000000, rem 0; start_i held 5 extra cycles in END -> result stable, then drops to FREE.
REQ-035 rst asserted at step 20 -> next cycle state FREE, ready_o=0, result_o=0.
